// File: rtl/fight_round_if.sv
// ==== fight_round_if : frame/hit/start inputs and round outputs of fight_round_ctrl (rev 1.0) ====
`default_nettype none

interface fight_round_if #(
   parameter int HW = 10
);
   logic          frame_tick;
   logic          p1hit;
   logic          p2hit;
   logic          start;
   logic [HW-1:0] p1_health;
   logic [HW-1:0] p2_health;
   logic          move_en;
   logic          flash;
   logic [1:0]    winner;
   logic [1:0]    state;

   modport master (
      output frame_tick, p1hit, p2hit, start,
      input  p1_health, p2_health, move_en, flash, winner, state
   );

   modport slave (
      input  frame_tick, p1hit, p2hit, start,
      output p1_health, p2_health, move_en, flash, winner, state
   );
endinterface

`default_nettype wire

// File: rtl/fight_round_ctrl.sv
// ==== fight_round_ctrl : per-frame hit collapsing, saturating damage and IDLE/FIGHT/FREEZE/KO sequencing (rev 1.0) ====
`default_nettype none

module fight_round_ctrl #(
   parameter int HEALTH_MAX    = 300,
   parameter int DAMAGE        = 100,
   parameter int FREEZE_FRAMES = 8,
   parameter int KO_FRAMES     = 120,
   parameter int HW            = 10
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   fight_round_if.slave bus
);

   localparam int CNT_MAX = (FREEZE_FRAMES > KO_FRAMES) ? FREEZE_FRAMES : KO_FRAMES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_FIGHT  = 2'd1;
   localparam logic [1:0] c_FREEZE = 2'd2;
   localparam logic [1:0] c_KO     = 2'd3;

   localparam logic [HW-1:0] c_HMAX     = HW'(HEALTH_MAX);
   localparam logic [HW-1:0] c_DMG      = HW'(DAMAGE);
   localparam logic [CW-1:0] c_FRZ_LAST = CW'(FREEZE_FRAMES - 1);
   localparam logic [CW-1:0] c_KO_LAST  = CW'(KO_FRAMES - 1);

   logic [1:0]    r_state, w_nstate;
   logic [CW-1:0] r_cnt, w_ncnt;
   logic [HW-1:0] r_p1h, r_p2h, w_np1h, w_np2h, w_sub1, w_sub2;
   logic [1:0]    r_win, w_nwin;
   logic          r_move, r_flash;
   logic          r_p1pend, r_p2pend;
   logic          w_hit1, w_hit2;

   function automatic logic [HW-1:0] f_sat_sub(input logic [HW-1:0] h);
      return (h > c_DMG) ? (h - c_DMG) : '0;
   endfunction

   always_comb begin
      // A hit arriving on the tick cycle belongs to the frame that is ending.
      w_hit1   = r_p1pend | bus.p1hit;
      w_hit2   = r_p2pend | bus.p2hit;
      w_sub1   = w_hit1 ? f_sat_sub(r_p1h) : r_p1h;
      w_sub2   = w_hit2 ? f_sat_sub(r_p2h) : r_p2h;
      w_nstate = r_state;
      w_ncnt   = r_cnt;
      w_np1h   = r_p1h;
      w_np2h   = r_p2h;
      w_nwin   = r_win;
      if (bus.frame_tick) begin
         case (r_state)
            c_IDLE: begin
               if (bus.start) begin
                  w_nstate = c_FIGHT;
                  w_nwin   = 2'd0;
               end
            end
            c_FIGHT: begin
               if (w_hit1 || w_hit2) begin
                  w_np1h = w_sub1;
                  w_np2h = w_sub2;
                  w_ncnt = '0;
                  if ((w_sub1 == '0) || (w_sub2 == '0)) begin
                     w_nstate = c_KO;
                     w_nwin   = {w_sub1 == '0, w_sub2 == '0};
                  end else begin
                     w_nstate = c_FREEZE;
                  end
               end
            end
            c_FREEZE: begin
               if (r_cnt == c_FRZ_LAST) begin
                  w_nstate = c_FIGHT;
                  w_ncnt   = '0;
               end else begin
                  w_ncnt = r_cnt + CW'(1);
               end
            end
            default: begin
               if (r_cnt == c_KO_LAST) begin
                  w_nstate = c_IDLE;
                  w_ncnt   = '0;
                  w_np1h   = c_HMAX;
                  w_np2h   = c_HMAX;
               end else begin
                  w_ncnt = r_cnt + CW'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= c_IDLE;
         r_cnt    <= '0;
         r_p1h    <= c_HMAX;
         r_p2h    <= c_HMAX;
         r_win    <= 2'd0;
         r_move   <= 1'b0;
         r_flash  <= 1'b0;
         r_p1pend <= 1'b0;
         r_p2pend <= 1'b0;
      end else begin
         r_state  <= w_nstate;
         r_cnt    <= w_ncnt;
         r_p1h    <= w_np1h;
         r_p2h    <= w_np2h;
         r_win    <= w_nwin;
         r_move   <= (w_nstate == c_FIGHT);
         // KO blinks: lit on even frame counts.
         r_flash  <= (w_nstate == c_FREEZE) || ((w_nstate == c_KO) && !w_ncnt[0]);
         r_p1pend <= bus.frame_tick ? 1'b0 : (r_p1pend | bus.p1hit);
         r_p2pend <= bus.frame_tick ? 1'b0 : (r_p2pend | bus.p2hit);
      end
   end

   assign bus.p1_health = r_p1h;
   assign bus.p2_health = r_p2h;
   assign bus.move_en   = r_move;
   assign bus.flash     = r_flash;
   assign bus.winner    = r_win;
   assign bus.state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_fight_round_ctrl.sv
// ==== tb_fight_round_ctrl : two instances (HEALTH_MAX 300 / 250) against a frame-level round model (rev 1.0) ====
`default_nettype none

module tb_fight_round_ctrl;

   localparam int DAMAGE        = 100;
   localparam int FREEZE_FRAMES = 8;
   localparam int KO_FRAMES     = 120;
   localparam int M_IDLE = 0, M_FIGHT = 1, M_FREEZE = 2, M_KO = 3;

   logic clk        = 1'b0;
   logic rst_n      = 1'b0;
   logic frame_tick = 1'b0;
   logic p1hit      = 1'b0;
   logic p2hit      = 1'b0;
   logic start      = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   int hmax [2] = '{300, 250};
   int m_mode [2];
   int m_h1   [2];
   int m_h2   [2];
   int m_win  [2];
   int m_age  [2];
   bit m_p1   [2];
   bit m_p2   [2];

   fight_round_if #(.HW(10)) if0 ();
   fight_round_if #(.HW(10)) if1 ();

   assign if0.frame_tick = frame_tick;
   assign if0.p1hit      = p1hit;
   assign if0.p2hit      = p2hit;
   assign if0.start      = start;
   assign if1.frame_tick = frame_tick;
   assign if1.p1hit      = p1hit;
   assign if1.p2hit      = p2hit;
   assign if1.start      = start;

   fight_round_ctrl #(.HEALTH_MAX(300)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   fight_round_ctrl #(.HEALTH_MAX(250)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   logic [31:0] o_state [2];
   logic [31:0] o_h1    [2];
   logic [31:0] o_h2    [2];
   logic [31:0] o_win   [2];
   logic [31:0] o_move  [2];
   logic [31:0] o_flash [2];

   assign o_state[0] = 32'(if0.state);
   assign o_h1[0]    = 32'(if0.p1_health);
   assign o_h2[0]    = 32'(if0.p2_health);
   assign o_win[0]   = 32'(if0.winner);
   assign o_move[0]  = 32'(if0.move_en);
   assign o_flash[0] = 32'(if0.flash);
   assign o_state[1] = 32'(if1.state);
   assign o_h1[1]    = 32'(if1.p1_health);
   assign o_h2[1]    = 32'(if1.p2_health);
   assign o_win[1]   = 32'(if1.winner);
   assign o_move[1]  = 32'(if1.move_en);
   assign o_flash[1] = 32'(if1.flash);

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      m_mode[k] = M_IDLE;
      m_h1[k]   = hmax[k];
      m_h2[k]   = hmax[k];
      m_win[k]  = 0;
      m_age[k]  = 0;
      m_p1[k]   = 1'b0;
      m_p2[k]   = 1'b0;
   endtask

   // One clock edge of round behaviour, expressed in frames and health points.
   task automatic model_step(input int k);
      bit e1, e2;
      e1 = m_p1[k] | p1hit;
      e2 = m_p2[k] | p2hit;
      if (!frame_tick) begin
         m_p1[k] = e1;
         m_p2[k] = e2;
         return;
      end
      m_p1[k] = 1'b0;
      m_p2[k] = 1'b0;
      case (m_mode[k])
         M_IDLE: if (start) begin
            m_mode[k] = M_FIGHT;
            m_win[k]  = 0;
         end
         M_FIGHT: if (e1 || e2) begin
            if (e1) m_h1[k] = (m_h1[k] - DAMAGE < 0) ? 0 : m_h1[k] - DAMAGE;
            if (e2) m_h2[k] = (m_h2[k] - DAMAGE < 0) ? 0 : m_h2[k] - DAMAGE;
            m_age[k] = 0;
            if (m_h1[k] == 0 || m_h2[k] == 0) begin
               m_mode[k] = M_KO;
               m_win[k]  = (m_h2[k] == 0 ? 1 : 0) + (m_h1[k] == 0 ? 2 : 0);
            end else begin
               m_mode[k] = M_FREEZE;
            end
         end
         M_FREEZE: begin
            m_age[k]++;
            if (m_age[k] == FREEZE_FRAMES) begin
               m_mode[k] = M_FIGHT;
               m_age[k]  = 0;
            end
         end
         default: begin
            m_age[k]++;
            if (m_age[k] == KO_FRAMES) begin
               m_mode[k] = M_IDLE;
               m_age[k]  = 0;
               m_h1[k]   = hmax[k];
               m_h2[k]   = hmax[k];
            end
         end
      endcase
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("state[%0d]", k),  o_state[k], m_mode[k]);
         check($sformatf("p1_health[%0d]", k), o_h1[k], m_h1[k]);
         check($sformatf("p2_health[%0d]", k), o_h2[k], m_h2[k]);
         check($sformatf("winner[%0d]", k), o_win[k], m_win[k]);
         check($sformatf("move_en[%0d]", k), o_move[k], (m_mode[k] == M_FIGHT) ? 1 : 0);
         check($sformatf("flash[%0d]", k), o_flash[k],
               ((m_mode[k] == M_FREEZE) || (m_mode[k] == M_KO && (m_age[k] % 2) == 0)) ? 1 : 0);
      end
   endtask

   task automatic cyc(input bit tk, input bit a, input bit b);
      frame_tick = tk;
      p1hit      = a;
      p2hit      = b;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) model_reset(k);
         else        model_step(k);
      end
      #1 check_all();
   endtask

   task automatic frame(input int len, input bit bh1, input bit bh2, input bit th1, input bit th2);
      for (int i = 0; i < len - 1; i++) cyc(1'b0, bh1, bh2);
      cyc(1'b1, th1, th2);
   endtask

   task automatic freeze_frames();
      repeat (FREEZE_FRAMES) frame(4, 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) model_reset(k);
      check_all();
      check("async_rst_state", 32'(if0.state), 0);
      check("async_rst_p1h", 32'(if0.p1_health), 300);
      check("async_rst_flash", 32'(if0.flash), 0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      rst_n = 1'b1;
   endtask

   initial begin
      int len, hm;
      bit a, b;
      for (int k = 0; k < 2; k++) model_reset(k);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      check("reset_state", 32'(if0.state), 0);
      check("reset_p1h_300", 32'(if0.p1_health), 300);
      check("reset_p2h_250", 32'(if1.p2_health), 250);
      rst_n = 1'b1;

      start = 1'b1;
      frame(4, 1'b0, 1'b0, 1'b0, 1'b0);
      check("start_state", 32'(if0.state), 1);
      check("start_move_en", 32'(if0.move_en), 1);
      start = 1'b0;

      frame(501, 1'b1, 1'b0, 1'b0, 1'b0);
      check("hold_hit_p1h", 32'(if0.p1_health), 200);
      check("hold_hit_p2h", 32'(if0.p2_health), 300);
      check("hold_hit_state", 32'(if0.state), 2);
      check("hold_hit_flash", 32'(if0.flash), 1);
      repeat (FREEZE_FRAMES - 1) frame(5, 1'b1, 1'b1, 1'b1, 1'b1);
      check("freeze_7_state", 32'(if0.state), 2);
      frame(5, 1'b1, 1'b1, 1'b1, 1'b1);
      check("freeze_8_state", 32'(if0.state), 1);
      check("freeze_no_dmg", 32'(if0.p1_health), 200);

      frame(6, 1'b0, 1'b0, 1'b1, 1'b0);
      check("tick_hit_p1h", 32'(if0.p1_health), 100);
      check("tick_hit_p1h_250", 32'(if1.p1_health), 50);
      freeze_frames();
      check("freeze_hits_p2h", 32'(if0.p2_health), 300);

      frame(4, 1'b0, 1'b1, 1'b0, 1'b0);
      check("pre_rst_p2h", 32'(if0.p2_health), 200);
      async_reset();

      start = 1'b1;
      frame(4, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 3; r++) begin
         frame(5, 1'b1, 1'b1, 1'b0, 1'b0);
         if (r < 2) freeze_frames();
      end
      check("draw_state", 32'(if0.state), 3);
      check("draw_winner", 32'(if0.winner), 3);
      check("draw_p1h", 32'(if0.p1_health), 0);
      check("draw_winner_250", 32'(if1.winner), 3);
      repeat (KO_FRAMES) frame(3, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ko_end_state", 32'(if0.state), 0);
      check("ko_end_reload", 32'(if0.p2_health), 300);
      frame(3, 1'b0, 1'b0, 1'b0, 1'b0);
      check("held_start_restart", 32'(if0.state), 1);
      check("restart_winner", 32'(if0.winner), 0);
      start = 1'b0;

      for (int r = 0; r < 3; r++) begin
         frame(4, 1'b0, 1'b1, 1'b0, 1'b0);
         if (r == 0) check("p2_first_hit_250", 32'(if1.p2_health), 150);
         if (r < 2) freeze_frames();
      end
      check("p2_sat_zero_250", 32'(if1.p2_health), 0);
      check("p2_ko_winner_250", 32'(if1.winner), 1);
      repeat (KO_FRAMES) frame(3, 1'b1, 1'b0, 1'b0, 1'b0);
      check("idle_reload_p1h_250", 32'(if1.p1_health), 250);
      check("idle_reload_p2h_250", 32'(if1.p2_health), 250);
      check("idle_winner_held", 32'(if1.winner), 1);

      start = 1'b1;
      frame(3, 1'b0, 1'b0, 1'b0, 1'b0);
      start = 1'b0;
      for (int r = 0; r < 3; r++) begin
         frame(4, 1'b1, 1'b1, 1'b0, 1'b0);
         if (r < 2) freeze_frames();
      end
      repeat (5) frame(3, 1'b0, 1'b0, 1'b0, 1'b0);
      check("mid_ko_state", 32'(if0.state), 3);
      async_reset();
      repeat (10) frame(3, 1'b0, 1'b0, 1'b0, 1'b0);
      check("idle_after_rst", 32'(if0.state), 0);

      repeat (500) begin
         len   = $urandom_range(2, 10);
         hm    = $urandom_range(0, 3);
         start = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < len - 1; i++) begin
            a = hm[0] && ($urandom_range(0, 7) == 0);
            b = hm[1] && ($urandom_range(0, 7) == 0);
            cyc(1'b0, a, b);
         end
         cyc(1'b1, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
         if ($urandom_range(0, 199) == 0) async_reset();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fight_round_ctrl.md
Name: fight_round_ctrl

Overview:
- Round and damage controller for the two-player fighting datapath. It sits between the per-pixel hit detectors and the health-bar and player-motion logic.
- Collapses per-pixel p1hit/p2hit strobes into at most one hit per player per frame.
- Applies saturating damage and sequences the round through IDLE, FIGHT, FREEZE and KO.
- Drives move_en, a hit-flash flag and the winner code to the movement and rgb logic.

Parameters:
HEALTH_MAX, 300, health value loaded at round start (must be < 2^HW)
DAMAGE, 100, health subtracted per registered hit
FREEZE_FRAMES, 8, frames of hit-stop after a non-lethal hit
KO_FRAMES, 120, frames the KO state is held before returning to IDLE
HW, 10, health width in bits

Ports:
clk  in  1  system clock (pixel-domain clock shared with gen_sync)
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame, generated synchronously from the v_sync falling edge
p1hit  in  1  player 1 hit this pixel (p2 kick overlaps p1 sprite)
p2hit  in  1  player 2 hit this pixel
start  in  1  level; round start request (switch)
p1_health  out  HW  player 1 health, drives health-bar width
p2_health  out  HW  player 2 health
move_en  out  1  1 = position update allowed at this frame_tick
flash  out  1  1 = draw hit-flash colour
winner  out  2  0 none, 1 p1 wins, 2 p2 wins, 3 draw
state  out  2  0 IDLE, 1 FIGHT, 2 FREEZE, 3 KO

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, p1_health=p2_health=HEALTH_MAX, winner=0, move_en=0, flash=0.
  - Pending bits cleared, frame counter=0.
- All outputs are registered and change only on the clk rising edge.
- Hit latching:
  - p1_pend sets on any cycle with p1hit=1; p2_pend likewise.
  - On a frame_tick cycle the effective hit is hit_eff = pend | hit (the current-cycle hit belongs to the ending frame).
  - Pending bits clear on every frame_tick, in every state.
- Damage is applied only on a frame_tick cycle in FIGHT:
  - new_h = (h > DAMAGE) ? h - DAMAGE : 0, saturating and never wrapping.
  - When both hit_eff bits are set, both players are damaged in the same tick.
- IDLE:
  - move_en=0, flash=0, healths held at HEALTH_MAX.
  - frame_tick with start=1 -> FIGHT; winner cleared to 0.
- FIGHT:
  - move_en=1, flash=0.
  - On frame_tick with any hit_eff, damage is applied.
  - If either new health is 0 -> KO. winner = 1 if only p2 reaches 0, 2 if only p1 reaches 0, 3 if both; counter=0.
  - Otherwise -> FREEZE; counter=0.
  - No hits -> stay in FIGHT.
- FREEZE:
  - move_en=0, flash=1.
  - Hits are ignored: pending bits are still cleared per tick, no damage.
  - counter increments per frame_tick. At the tick where counter reaches FREEZE_FRAMES-1 -> FIGHT and counter=0, so FREEZE lasts exactly FREEZE_FRAMES ticks.
- KO:
  - move_en=0, flash=1 on even counter values and 0 on odd (blink), winner held.
  - At the tick where counter reaches KO_FRAMES-1 -> IDLE; healths reload to HEALTH_MAX, winner stays until the next start.
- start is sampled only in IDLE and only on frame_tick. Holding start=1 through KO restarts on the first tick in IDLE.
- frame_tick and hit in the same cycle in FREEZE/KO: hit discarded.
- rst_n asserted mid-FREEZE or KO: immediate return to reset values, no partial damage retained.
- Counter width is clog2(max(FREEZE_FRAMES, KO_FRAMES)) bits.

Test Plan:
- Reset then start=1, one frame_tick -> state=FIGHT, move_en=1, p1_health=p2_health=300, winner=0.
- In FIGHT, p1hit high for 500 cycles within one frame, then tick -> p1_health=200, p2_health=300, state=FREEZE, flash=1. After exactly 8 further ticks -> state=FIGHT.
- p1hit and p2hit both in one frame, repeated 3 frames (each after the freeze expires) -> both healths 300->200->100->0, state=KO, winner=3.
- HEALTH_MAX=250, three p2 hits -> p2_health 150, 50, then 0 (no wrap), winner=1. After 120 ticks -> IDLE, both healths 250, winner still 1.
- p1hit pulses only in the frame_tick cycle -> counted for the ending frame (p1_health -100). Hits during FREEZE frames -> no health change.
- rst_n=0 asynchronously mid-KO, no clk edge -> outputs at reset values immediately. Release with start=0 -> IDLE held across 10 ticks.
